// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter: shares one OBI memory port between the instruction and
// data request ports of the core. Outstanding transactions are tracked in
// an in-order source-ID FIFO so every response is steered back to the port
// that issued it. The address phase is held stable until grant.
//
// Optional build macro: OBI_ARB_ROUND_ROBIN_EN
//   defined   -> round-robin tie-break with a 1-bit last-winner register
//   undefined -> fixed priority, data over instr
//
// Handshake: a beat is transferred on any cycle where req && gnt are both
// high. The winning request is never withdrawn while ungranted (HOLD). Every
// granted transaction, write or read, is answered by exactly one rvalid pulse,
// and those pulses arrive in grant order.
module obi_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   instr_req_i,
    input  logic [ADDR_WIDTH-1:0]                  instr_addr_i,
    output logic                                   instr_gnt_o,
    output logic                                   instr_rvalid_o,
    output logic [31:0]                            instr_rdata_o,
    input  logic                                   data_req_i,
    input  logic [ADDR_WIDTH-1:0]                  data_addr_i,
    input  logic                                   data_we_i,
    input  logic [3:0]                             data_be_i,
    input  logic [31:0]                            data_wdata_i,
    output logic                                   data_gnt_o,
    output logic                                   data_rvalid_o,
    output logic [31:0]                            data_rdata_o,
    output logic                                   mem_req_o,
    output logic [ADDR_WIDTH-1:0]                  mem_addr_o,
    output logic                                   mem_we_o,
    output logic [3:0]                             mem_be_o,
    output logic [31:0]                            mem_wdata_o,
    input  logic                                   mem_gnt_i,
    input  logic                                   mem_rvalid_i,
    input  logic [31:0]                            mem_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   err_o,
    output logic                                   state_o
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic SRC_INSTR = 1'b0;
    localparam logic SRC_DATA  = 1'b1;

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

    state_e                     state_q, state_d;
    logic                       sel_q, sel_d;
    logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       err_q, err_d;
`ifdef OBI_ARB_ROUND_ROBIN_EN
    logic                       last_q, last_d;
`endif

    logic win_valid;
    logic win_sel;
    logic cur_sel;
    logic mem_req;
    logic push;
    logic pop;
    logic fifo_full;
    logic fifo_empty;
    logic head;

    assign fifo_full  = (cnt_q == CNT_FULL);
    assign fifo_empty = (cnt_q == '0);
    assign head       = fifo_q[rd_ptr_q];

    // Pick the IDLE-state winner among the two live requests.
    always_comb begin
        win_valid = instr_req_i | data_req_i;
`ifdef OBI_ARB_ROUND_ROBIN_EN
        // On a tie, the source that did not win last time goes first.
        if (instr_req_i && data_req_i) begin
            win_sel = ~last_q;
        end else begin
            win_sel = data_req_i;
        end
`else
        // Fixed priority: data wins whenever it requests.
        win_sel = data_req_i;
`endif
    end

    // FSM next state: a request left ungranted in IDLE is latched into HOLD.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cur_sel = win_sel;
        mem_req = 1'b0;
        case (state_q)
            IDLE: begin
                cur_sel = win_sel;
                mem_req = win_valid && !fifo_full;
                if (mem_req && !mem_gnt_i) begin
                    state_d = HOLD;
                    sel_d   = win_sel;
                end
            end
            HOLD: begin
                // FIFO had room on entry and nothing was pushed since.
                cur_sel = sel_q;
                mem_req = 1'b1;
                if (mem_gnt_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (rst_i) begin
            mem_req = 1'b0;
        end
    end

    assign push = mem_req && mem_gnt_i;
    assign pop  = mem_rvalid_i && !fifo_empty && !rst_i;

    // Address-phase mux from the selected source; zeros when idle.
    always_comb begin
        mem_req_o   = mem_req;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_wdata_o = 32'h0;
        if (mem_req) begin
            if (cur_sel == SRC_DATA) begin
                mem_addr_o  = data_addr_i;
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_addr_o  = instr_addr_i;
                mem_we_o    = 1'b0;
                mem_be_o    = 4'hF;
                mem_wdata_o = 32'h0;
            end
        end
    end

    // Grants and response steering, all combinational.
    always_comb begin
        instr_gnt_o    = push && (cur_sel == SRC_INSTR);
        data_gnt_o     = push && (cur_sel == SRC_DATA);
        instr_rvalid_o = pop && (head == SRC_INSTR);
        data_rvalid_o  = pop && (head == SRC_DATA);
        instr_rdata_o  = mem_rdata_i;
        data_rdata_o   = mem_rdata_i;
    end

    // ID FIFO bookkeeping and the sticky unexpected-response flag.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        if (push) begin
            fifo_d[wr_ptr_q] = cur_sel;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        // A response with nothing outstanding is dropped and flagged.
        if (mem_rvalid_i && fifo_empty) begin
            err_d = 1'b1;
        end
    end

`ifdef OBI_ARB_ROUND_ROBIN_EN
    // Remember who won the last granted handshake.
    always_comb begin
        last_d = push ? cur_sel : last_q;
    end
`endif

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            sel_q    <= SRC_INSTR;
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
`ifdef OBI_ARB_ROUND_ROBIN_EN
            last_q   <= SRC_DATA;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`ifdef OBI_ARB_ROUND_ROBIN_EN
            last_q   <= last_d;
`endif
        end
    end

    assign outstanding_o = cnt_q;
    assign err_o         = err_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Testbench for obi_mem_arbiter: per-cycle vector table (inputs plus
// expected address-phase outputs and registered state) and a queue of
// expected response routing filled at each expected grant.
module tb_obi_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        data_req;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  outstanding;
  logic        err;
  logic        state;

  obi_mem_arbiter #(
    .MAX_OUTSTANDING(2),
    .ADDR_WIDTH(32)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
    .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we),
    .data_be_i(data_be), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt),
    .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .outstanding_o(outstanding), .err_o(err), .state_o(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic [31:0] da;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] dwd;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        e_ig;
    logic        e_dg;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [1:0]  e_out;
    logic        e_err;
    logic        e_st;
  } vec_t;

  vec_t       vecs[$];
  logic [0:0] exp_q[$];
  int         checks;
  int         errors;

  task automatic add(input logic r, input logic ir, input logic [31:0] ia,
                     input logic dr, input logic [31:0] da, input logic dwe,
                     input logic [3:0] dbe, input logic [31:0] dwd,
                     input logic g, input logic rv, input logic [31:0] rd,
                     input logic e_ig, input logic e_dg, input logic e_req,
                     input logic [31:0] e_addr, input logic e_we,
                     input logic [3:0] e_be, input logic [31:0] e_wd,
                     input logic [1:0] e_out, input logic e_err, input logic e_st);
    vec_t v;
    v.rst = r; v.ir = ir; v.ia = ia; v.dr = dr; v.da = da; v.dwe = dwe;
    v.dbe = dbe; v.dwd = dwd; v.gnt = g; v.rv = rv; v.rd = rd;
    v.e_ig = e_ig; v.e_dg = e_dg; v.e_req = e_req; v.e_addr = e_addr;
    v.e_we = e_we; v.e_be = e_be; v.e_wd = e_wd; v.e_out = e_out;
    v.e_err = e_err; v.e_st = e_st;
    vecs.push_back(v);
  endtask

  // driver
  task automatic drive(input vec_t v);
    rst        = v.rst;
    instr_req  = v.ir;
    instr_addr = v.ia;
    data_req   = v.dr;
    data_addr  = v.da;
    data_we    = v.dwe;
    data_be    = v.dbe;
    data_wdata = v.dwd;
    mem_gnt    = v.gnt;
    mem_rvalid = v.rv;
    mem_rdata  = v.rd;
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // scoreboard: compare one vector's outputs, route responses through exp_q
  task automatic check_vec(input vec_t v, input int idx);
    logic [0:0] id;
    logic       exp_ir;
    logic       exp_dr;
    check("instr_gnt", idx, {31'b0, instr_gnt}, {31'b0, v.e_ig});
    check("data_gnt", idx, {31'b0, data_gnt}, {31'b0, v.e_dg});
    check("mem_req", idx, {31'b0, mem_req}, {31'b0, v.e_req});
    check("mem_addr", idx, mem_addr, v.e_addr);
    check("mem_we", idx, {31'b0, mem_we}, {31'b0, v.e_we});
    check("mem_be", idx, {28'b0, mem_be}, {28'b0, v.e_be});
    check("mem_wdata", idx, mem_wdata, v.e_wd);
    check("outstanding", idx, {30'b0, outstanding}, {30'b0, v.e_out});
    check("err", idx, {31'b0, err}, {31'b0, v.e_err});
    check("state", idx, {31'b0, state}, {31'b0, v.e_st});
    exp_ir = 1'b0;
    exp_dr = 1'b0;
    if (v.rv && !v.rst && exp_q.size() > 0) begin
      id = exp_q.pop_front();
      exp_ir = (id == 1'b0);
      exp_dr = (id == 1'b1);
    end
    check("instr_rvalid", idx, {31'b0, instr_rvalid}, {31'b0, exp_ir});
    check("data_rvalid", idx, {31'b0, data_rvalid}, {31'b0, exp_dr});
    if (exp_ir) check("instr_rdata", idx, instr_rdata, v.rd);
    if (exp_dr) check("data_rdata", idx, data_rdata, v.rd);
    if (v.e_ig) exp_q.push_back(1'b0);
    if (v.e_dg) exp_q.push_back(1'b1);
    if (v.rst) exp_q.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    // reset state
    add(0, 0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0, 0,0,0);
    // tie: instr 0x84 vs data write 0x1000
`ifdef OBI_ARB_ROUND_ROBIN_EN
    add(0, 1,'h84, 1,'h1000,1,'h3,'hDEADBEEF, 1,0,0, 1,0,1,'h84,0,'hF,0, 0,0,0);
    add(0, 0,0, 1,'h1000,1,'h3,'hDEADBEEF, 1,0,0, 0,1,1,'h1000,1,'h3,'hDEADBEEF, 1,0,0);
`else
    add(0, 1,'h84, 1,'h1000,1,'h3,'hDEADBEEF, 1,0,0, 0,1,1,'h1000,1,'h3,'hDEADBEEF, 0,0,0);
    add(0, 1,'h84, 0,0,0,0,0, 1,0,0, 1,0,1,'h84,0,'hF,0, 1,0,0);
`endif
    add(0, 0,0, 0,0,0,0,0, 0,1,'h11111111, 0,0,0,0,0,0,0, 2,0,0);
    add(0, 0,0, 0,0,0,0,0, 0,1,'h22222222, 0,0,0,0,0,0,0, 1,0,0);
    // single instr read at 0x80
    add(0, 1,'h80, 0,0,0,0,0, 1,0,0, 1,0,1,'h80,0,'hF,0, 0,0,0);
    add(0, 0,0, 0,0,0,0,0, 0,1,'h13, 0,0,0,0,0,0,0, 1,0,0);
    add(0, 0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0, 0,0,0);
    // data held without grant, instr arrives and must wait
    add(0, 0,0, 1,'h2000,0,'hF,0, 0,0,0, 0,0,1,'h2000,0,'hF,0, 0,0,0);
    add(0, 1,'h88, 1,'h2000,0,'hF,0, 0,0,0, 0,0,1,'h2000,0,'hF,0, 0,0,1);
    add(0, 1,'h88, 1,'h2000,0,'hF,0, 0,0,0, 0,0,1,'h2000,0,'hF,0, 0,0,1);
    add(0, 1,'h88, 1,'h2000,0,'hF,0, 1,0,0, 0,1,1,'h2000,0,'hF,0, 0,0,1);
    add(0, 1,'h88, 0,0,0,0,0, 1,0,0, 1,0,1,'h88,0,'hF,0, 1,0,0);
    add(0, 0,0, 0,0,0,0,0, 0,1,'h33333333, 0,0,0,0,0,0,0, 2,0,0);
    add(0, 0,0, 0,0,0,0,0, 0,1,'h44444444, 0,0,0,0,0,0,0, 1,0,0);
    add(0, 0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0, 0,0,0);
    // FIFO full: third read blocked, pop does not unblock same cycle
    add(0, 1,'h100, 0,0,0,0,0, 1,0,0, 1,0,1,'h100,0,'hF,0, 0,0,0);
    add(0, 1,'h104, 0,0,0,0,0, 1,0,0, 1,0,1,'h104,0,'hF,0, 1,0,0);
    add(0, 1,'h108, 0,0,0,0,0, 1,0,0, 0,0,0,0,0,0,0, 2,0,0);
    add(0, 1,'h108, 0,0,0,0,0, 1,1,'h55555555, 0,0,0,0,0,0,0, 2,0,0);
    add(0, 1,'h108, 0,0,0,0,0, 1,0,0, 1,0,1,'h108,0,'hF,0, 1,0,0);
    add(0, 0,0, 0,0,0,0,0, 0,1,'h66666666, 0,0,0,0,0,0,0, 2,0,0);
    // simultaneous push and pop keeps the count
    add(0, 1,'h10C, 0,0,0,0,0, 1,1,'h77777777, 1,0,1,'h10C,0,'hF,0, 1,0,0);
    add(0, 0,0, 0,0,0,0,0, 0,1,'h88888888, 0,0,0,0,0,0,0, 1,0,0);
    add(0, 0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0, 0,0,0);
    // stray response: sticky error, nothing forwarded, cleared by reset
    add(0, 0,0, 0,0,0,0,0, 0,1,'h99999999, 0,0,0,0,0,0,0, 0,0,0);
    add(0, 0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0, 0,1,0);
    add(0, 0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0, 0,1,0);
    add(1, 0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0, 0,1,0);
    add(0, 0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0, 0,0,0);
    // reset while in HOLD with one outstanding
    add(0, 1,'h200, 0,0,0,0,0, 1,0,0, 1,0,1,'h200,0,'hF,0, 0,0,0);
    add(0, 0,0, 1,'h300,1,'hF,'h12345678, 0,0,0, 0,0,1,'h300,1,'hF,'h12345678, 1,0,0);
    add(1, 0,0, 1,'h300,1,'hF,'h12345678, 0,0,0, 0,0,0,0,0,0,0, 1,0,1);
    add(0, 0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0, 0,0,0);
    add(0, 0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0, 0,0,0);

    // initial reset
    rst = 1'b1;
    instr_req = 1'b0; instr_addr = '0;
    data_req = 1'b0; data_addr = '0; data_we = 1'b0; data_be = '0; data_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      @(negedge clk);
      check_vec(vecs[i], i);
    end

    // every grant must have been answered or flushed
    check("exp_q_drained", vecs.size(), exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/obi_mem_arbiter.md
Name: obi_mem_arbiter

Overview:
- Shares one OBI-style memory slave port (single-port RAM or memory-mapped pseudo-peripheral bus) between the core's instruction and data request ports.
- Sits between cv32e40p_core and the memory model in the core testbench.
- Tracks outstanding transactions in an in-order ID FIFO and routes each read response back to the requester that issued it.
- Holds the address phase stable until grant, as OBI requires.

Parameters:
- MAX_OUTSTANDING, 2, depth of the response-ID FIFO (number of granted, unanswered transactions); must be >= 1.
- ADDR_WIDTH, 32, address width on all ports.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- instr_req_i  in  1  instruction request
- instr_addr_i  in  ADDR_WIDTH  instruction address
- instr_gnt_o  out  1  instruction grant
- instr_rvalid_o  out  1  instruction response valid
- instr_rdata_o  out  32  instruction read data
- data_req_i  in  1  data request
- data_addr_i  in  ADDR_WIDTH  data address
- data_we_i  in  1  data write enable
- data_be_i  in  4  data byte enables
- data_wdata_i  in  32  data write data
- data_gnt_o  out  1  data grant
- data_rvalid_o  out  1  data response valid
- data_rdata_o  out  32  data read data
- mem_req_o  out  1  memory request
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  memory byte enables
- mem_wdata_o  out  32  memory write data
- mem_gnt_i  in  1  memory grant
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  32  memory read data
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  number of granted, unanswered transactions
- err_o  out  1  sticky protocol error

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous, active-high, on rst_i.
- Reset values: FIFO empty, outstanding_o=0, err_o=0, state IDLE, lock register cleared. All gnt/rvalid outputs and mem_req_o are 0 while rst_i=1.
- States:
  - IDLE: no held request.
  - HOLD: mem_req_o was asserted with mem_gnt_i=0. The winning source is latched and kept until grant.
- Arbitration in IDLE:
  - A winner is chosen combinationally from instr_req_i and data_req_i. Default policy is fixed priority, data over instr.
  - mem_req_o = (winner exists) && !fifo_full.
  - If mem_gnt_i=1 in the same cycle: stay IDLE.
  - If mem_gnt_i=0: go to HOLD with the winner latched.
- HOLD:
  - mem_req_o=1 for the latched source only. The other requester cannot preempt.
  - On mem_gnt_i=1: go to IDLE.
  - A full FIFO cannot occur in HOLD, because entry required !full and no push happens until grant.
- Muxing:
  - mem_* address-phase signals come from the selected source.
  - For instr: mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
  - With no request, mem_* outputs are 0.
- Grant:
  - instr_gnt_o / data_gnt_o = mem_gnt_i && mem_req_o && (selected==that source). This is combinational, 0-cycle.
  - The non-selected requester sees gnt=0.
- FIFO:
  - Granted handshake (mem_req_o && mem_gnt_i) pushes the source ID (0=instr, 1=data).
  - mem_rvalid_i pops the head and steers the response: head==0 gives instr_rvalid_o=1, head==1 gives data_rvalid_o=1, both combinational with mem_rvalid_i.
  - mem_rdata_i is driven to both rdata outputs.
  - Writes also produce an rvalid and are tracked identically.
  - Simultaneous push and pop: count unchanged, ordering preserved.
  - Full (count==MAX_OUTSTANDING): no new mem_req_o. A pop in the same cycle does not unblock; the request is issued next cycle.
- Error:
  - mem_rvalid_i with the FIFO empty sets err_o (sticky until reset).
  - The response is dropped: no rvalid to either port and no underflow of the count.
- Reset mid-operation: all state and FIFO are cleared immediately. Later responses for pre-reset transactions hit an empty FIFO and set err_o. The bench must not generate them.

Optional Feature:
- Macro: OBI_ARB_ROUND_ROBIN_EN.
- Defined:
  - IDLE arbitration uses a 1-bit last-winner register, reset to data (so instr wins the first tie).
  - On a tie, the source not granted last wins.
  - The register updates only on a granted handshake.
- Undefined: fixed priority, data over instr. No last-winner register is present.

Test Plan:
- Single instr read at 0x80, mem_gnt_i=1 same cycle, mem_rvalid_i next cycle with rdata 0x00000013 -> instr_gnt_o=1 in cycle 0; instr_rvalid_o=1, instr_rdata_o=0x00000013 in cycle 1; data_rvalid_o=0; outstanding_o returns 0.
- Simultaneous instr 0x84 and data write 0x1000 (be=4'b0011, wdata=0xDEADBEEF), mem_gnt_i=1 for 2 cycles -> default: data granted first (mem_we_o=1, mem_be_o=0x3), then instr; responses return in order data then instr. With OBI_ARB_ROUND_ROBIN_EN: instr first, then data.
- Data request to 0x2000, mem_gnt_i low for 3 cycles, instr_req_i raised in cycle 1 -> mem_addr_o stays 0x2000 every cycle until grant; instr_gnt_o=0 throughout; instr granted on the cycle after data's grant.
- MAX_OUTSTANDING=2: three back-to-back instr reads with mem_gnt_i=1 and no rvalid -> first two granted, outstanding_o=2, third held with mem_req_o=0. One mem_rvalid_i -> third issued the following cycle.
- mem_rvalid_i pulse with outstanding_o=0 -> err_o=1 and stays 1; no rvalid on either port. rst_i=1 for one cycle -> err_o=0, outstanding_o=0.
- rst_i asserted in HOLD with 1 outstanding -> next cycle state IDLE, outstanding_o=0, mem_req_o=0 while both requests are low.
